// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

    localparam logic [2:0]  DEF_PAT_101 = 3'b101;
    localparam int unsigned REP_W       = 4;
    localparam int unsigned GAP_W       = 4;

endpackage

// File: rtl/seq_gen_101_if.sv
// Control/data bundle between a pattern-generator user (master) and the generator (slave).
interface seq_gen_101_if #(
    parameter int unsigned W = 3
);
    import seq_pkg::*;

    logic             start;
    logic             abort;
    logic             use_def;
    logic [W-1:0]     pattern;
    logic [REP_W-1:0] rep;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, use_def, pattern, rep,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  start, abort, use_def, pattern, rep,
        output x, x_valid, busy, done
    );

endinterface

// File: rtl/seq_gen_cnt.sv
// Loadable up/down counter; tc flags when the count equals the supplied terminal value.
module seq_gen_cnt #(
    parameter int unsigned Width = 4,
    parameter bit          Down  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [Width-1:0] load_val,
    input  logic [Width-1:0] term,
    output logic             tc
);

    logic [Width-1:0] cnt_q;

    // load wins over en so the owner can restart the count on the same edge it would step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= Down ? cnt_q - Width'(1) : cnt_q + Width'(1);
        end
    end

    assign tc = (cnt_q == term);

endmodule

// File: rtl/seq_gen_101.sv
// Serial pattern transmitter: shifts a W-bit pattern out MSB-first for rep+1 frames,
// with GAP idle cycles between frames. Moore FSM, all outputs registered.
module seq_gen_101 import seq_pkg::*; #(
    parameter int unsigned  W       = 3,
    parameter int unsigned  GAP     = 0,
    parameter logic [W-1:0] DEF_PAT = W'(DEF_PAT_101)
) (
    input logic          clk,
    input logic          rst,
    seq_gen_101_if.slave bus
);

    localparam int unsigned      BitW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [BitW-1:0]  BitLast = BitW'(W - 1);
    localparam logic [GAP_W-1:0] GapLast = GAP_W'((GAP != 0) ? GAP - 1 : 0);

    state_e           state_q;
    logic [W-1:0]     shreg_q;
    logic [REP_W-1:0] frm_q;
    logic             x_q;
    logic             x_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [W-1:0]     pat_sel;
    logic [W-1:0]     rot;
    logic             bit_tc;
    logic             gap_tc;

    assign pat_sel = bus.use_def ? DEF_PAT : bus.pattern;
    assign rot     = {shreg_q[W-2:0], shreg_q[W-1]};

    // Bit index within the current frame; held at 0 outside SHIFT and wrapped at the last bit.
    seq_gen_cnt #(
        .Width(BitW),
        .Down (1'b0)
    ) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    ((state_q != StShift) || bit_tc),
        .en      (state_q == StShift),
        .load_val('0),
        .term    (BitLast),
        .tc      (bit_tc)
    );

    seq_gen_cnt #(
        .Width(GAP_W),
        .Down (1'b0)
    ) u_gap_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q != StGap),
        .en      (state_q == StGap),
        .load_val('0),
        .term    (GapLast),
        .tc      (gap_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            frm_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q   <= StShift;
                        shreg_q   <= pat_sel;
                        frm_q     <= bus.rep;
                        x_q       <= pat_sel[W-1];
                        x_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StShift: begin
                    if (bus.abort || (bit_tc && frm_q == '0)) begin
                        state_q   <= StDone;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        // Rotation restores the original pattern after W steps, so no reload.
                        shreg_q <= rot;
                        x_q     <= shreg_q[W-2];
                        if (bit_tc) begin
                            frm_q <= frm_q - REP_W'(1);
                            if (GAP != 0) begin
                                state_q   <= StGap;
                                x_q       <= 1'b0;
                                x_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                StGap: begin
                    if (bus.abort) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_tc) begin
                        state_q   <= StShift;
                        x_q       <= shreg_q[W-1];
                        x_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_gen_101.sv
// Scoreboard bench for seq_gen_101: one default-config instance (W=3, GAP=0) and one
// W=4, GAP=2 instance, each checked against expected bit queues built from the frame rules.
module tb_seq_gen_101;

    localparam int unsigned    WA    = 3;
    localparam int unsigned    GA    = 0;
    localparam int unsigned    WB    = 4;
    localparam int unsigned    GB    = 2;
    localparam logic [WB-1:0]  DEF_B = 4'b1001;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_gen_101_if #(.W(WA)) ia ();
    seq_gen_101_if #(.W(WB)) ib ();

    seq_gen_101 #(.W(WA), .GAP(GA)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ia)
    );

    seq_gen_101 #(.W(WB), .GAP(GB), .DEF_PAT(DEF_B)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ib)
    );

    int errors = 0;
    int checks = 0;
    bit exp_q[2][$];
    int busy_cnt[2];
    int done_cnt[2];
    int gap_run[2];

    int         bits_seen = 0;
    int         det_pos[$];
    logic [2:0] hist = 3'b000;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {x, x_valid, busy, done}
    function automatic logic [3:0] outs(input bit sel);
        return sel ? {ib.x, ib.x_valid, ib.busy, ib.done} : {ia.x, ia.x_valid, ia.busy, ia.done};
    endfunction

    task automatic drive(input bit sel, input logic s, input logic a, input logic u,
                         input logic [15:0] p, input logic [3:0] r);
        if (sel) begin
            ib.start = s; ib.abort = a; ib.use_def = u; ib.pattern = p[WB-1:0]; ib.rep = r;
        end else begin
            ia.start = s; ia.abort = a; ia.use_def = u; ia.pattern = p[WA-1:0]; ia.rep = r;
        end
    endtask

    task automatic mon_step(input bit sel);
        logic [3:0] o;
        int         g;
        o = outs(sel);
        g = sel ? int'(GB) : int'(GA);
        if (o[2]) begin
            if (gap_run[sel] > 0) check("gap_len", gap_run[sel], g);
            gap_run[sel] = 0;
            check("bit_expected", int'(exp_q[sel].size() != 0), 1);
            if (exp_q[sel].size() != 0) check("bit", int'(o[3]), int'(exp_q[sel].pop_front()));
        end else begin
            check("x_idle_zero", int'(o[3]), 0);
            gap_run[sel] = o[1] ? gap_run[sel] + 1 : 0;
        end
        if (o[1]) busy_cnt[sel]++;
        if (o[0]) done_cnt[sel]++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_step(1'b0);
            mon_step(1'b1);
        end
    end

    // Reference overlapping 101 Moore detector fed by the gated default-instance stream.
    always @(posedge clk) hist <= {hist[1:0], ia.x & ia.x_valid};

    always @(negedge clk) begin
        if (hist == 3'b101) det_pos.push_back(bits_seen);
        if (ia.x_valid) bits_seen++;
    end

    task automatic run(input bit sel, input bit use_def, input logic [15:0] pat, input int rep,
                       input int abort_at, input bit hold);
        int          w, g, nbits, exp_busy, nv;
        logic [15:0] p;
        logic [3:0]  o;
        bit          fin;
        w        = sel ? int'(WB) : int'(WA);
        g        = sel ? int'(GB) : int'(GA);
        p        = use_def ? (sel ? 16'(DEF_B) : 16'(3'b101)) : pat;
        nbits    = (rep + 1) * w;
        exp_busy = nbits + rep * g;
        if (abort_at > 0) begin
            nbits    = abort_at;
            exp_busy = abort_at;
        end
        @(negedge clk); #1;
        busy_cnt[sel] = 0;
        done_cnt[sel] = 0;
        for (int i = 0; i < nbits; i++) exp_q[sel].push_back(p[w - 1 - (i % w)]);
        drive(sel, 1'b1, 1'b0, use_def, pat, 4'(rep));
        nv  = 0;
        fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk); #1;
            o = outs(sel);
            if (c == 0) check("start_latency", int'(o[2]), 1);
            if (o[2]) nv++;
            if (o[0]) begin
                fin = 1'b1;
                check("done_no_valid", int'(o[2]), 0);
                check("done_count", done_cnt[sel], 1);
                check("busy_cycles", busy_cnt[sel], exp_busy);
                check("bits_left", exp_q[sel].size(), 0);
            end
            // Captured inputs are scrambled after start to show they are not re-read.
            drive(sel, hold, o[2] && (nv == abort_at), 1'($urandom), 16'($urandom),
                  4'($urandom));
        end
        if (!fin) check("done_timeout", 0, 1);
        if (!hold) begin
            @(negedge clk); #1;
            o = outs(sel);
            check("done_one_cycle", int'(o[0]), 0);
            check("idle_busy_low", int'(o[1]), 0);
        end
    endtask

    task automatic reset_mid_gap();
        logic [3:0] o;
        bit         seen_gap;
        seen_gap = 1'b0;
        @(negedge clk); #1;
        exp_q[1].delete();
        for (int i = 0; i < int'(WB); i++) exp_q[1].push_back(1'((4'b1011 >> (WB - 1 - i)) & 1));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h000B, 4'd2);
        for (int c = 0; c < 40 && !seen_gap; c++) begin
            @(negedge clk); #1;
            o = outs(1'b1);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h000B, 4'd2);
            if (o[1] && !o[2]) seen_gap = 1'b1;
        end
        check("gap_reached", int'(seen_gap), 1);
        rst = 1'b1;
        #1;
        check("rst_async_clear", int'(outs(1'b1)), 0);
        exp_q[1].delete();
        @(negedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            o = outs(1'b1);
            check("post_rst_idle", int'(o[2]), 0);
        end
    endtask

    task automatic loopback();
        int base;
        det_pos.delete();
        base = bits_seen;
        run(1'b0, 1'b1, 16'h0002, 1, 0, 1'b0);
        check("det_count", det_pos.size(), 2);
        if (det_pos.size() >= 2) begin
            check("det_after_bit3", det_pos[0] - base, 3);
            check("det_after_bit6", det_pos[1] - base, 6);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", int'(outs(1'b0)), 0);
        check("reset_b", int'(outs(1'b1)), 0);
        rst = 1'b0;

        run(1'b0, 1'b1, 16'h0000, 0, 0, 1'b0);  // default 101, one frame
        run(1'b1, 1'b0, 16'h000C, 2, 0, 1'b0);  // 1100 x3 with 2-cycle gaps
        run(1'b0, 1'b0, 16'h0006, 1, 0, 1'b1);  // start held high throughout
        run(1'b0, 1'b0, 16'h0003, 0, 0, 1'b0);  // restart in the cycle after done
        run(1'b1, 1'b0, 16'h000D, 3, 2, 1'b0);  // abort on 2nd bit
        reset_mid_gap();
        loopback();

        for (int k = 0; k < 12; k++) begin
            bit sel;
            int w;
            int ab;
            sel = 1'($urandom_range(0, 1));
            w   = sel ? int'(WB) : int'(WA);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, w)) : 0;
            run(sel, 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), ab, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_gen_101.md
# seq_gen_101

Serial bit-pattern transmitter. It drives the single-bit stream that the team's Moore sequence detectors consume. On a start request it loads a W-bit pattern (default 101) and shifts it out MSB-first, one bit per clock, repeated a programmable number of frames with an optional idle gap between frames. It is used as the stimulus and loopback source for the detector blocks and as a standalone framing generator.

## Interface
- `W`, default 3: pattern width in bits, range 2..16.
- `GAP`, default 0: idle cycles inserted between consecutive frames, range 0..15.
- `DEF_PAT`, default 3'b101: pattern loaded when `use_def`=1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transmission; sampled only in IDLE.
- `abort` in 1: terminate the transmission at the next edge.
- `use_def` in 1: 1 selects `DEF_PAT`, 0 selects `pattern`.
- `pattern` in W: pattern to send, MSB first; captured at start.
- `rep` in 4: number of frames minus one; 0..15 gives 1..16 frames; captured at start.
- `x` out 1: serial data bit; 0 whenever `x_valid`=0.
- `x_valid` out 1: `x` carries a pattern bit this cycle.
- `busy` out 1: high in SHIFT and GAP.
- `done` out 1: one-cycle pulse at the end of a completed or aborted transmission.

## Operation
- Moore FSM; all outputs are registered and depend only on state and datapath registers.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - `start`=1 captures the pattern into `shreg` and `rep` into `frm_cnt`, clears `bit_cnt`, and moves to SHIFT.
  - Otherwise the FSM stays in IDLE.
- SHIFT:
  - `x`=`shreg[W-1]` and `x_valid`=1.
  - Each cycle `shreg` rotates left by one and `bit_cnt` increments.
  - At `bit_cnt`=W-1 (last bit of the frame):
    - if `frm_cnt`=0, go to DONE;
    - else decrement `frm_cnt` and go to GAP if `GAP`>0, otherwise stay in SHIFT.
  - Because the register rotates, the original pattern is restored for the next frame without a reload.
- GAP:
  - `x`=0, `x_valid`=0.
  - `gap_cnt` counts `GAP` cycles, then the FSM returns to SHIFT with `bit_cnt`=0.
- DONE:
  - `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- Abort:
  - `abort`=1 in SHIFT or GAP goes to DONE at the next edge, which drives `x_valid` low.
  - The partial frame is not completed.
  - `abort` is ignored in IDLE and DONE.
- Priority: `rst` > `abort` > normal sequencing.
- `start` while `busy` or in DONE is ignored; it is not queued.
- Inputs `pattern`, `rep` and `use_def` may change after capture without effect.
- Counter widths:
  - `bit_cnt` is $clog2(W) bits.
  - `gap_cnt` is 4 bits.
  - `frm_cnt` is 4 bits, decrements only and never wraps.

## Timing
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, state=IDLE, all counters 0, `shreg`=0.
- Start latency: with `start` sampled high at edge N, the first bit appears after edge N, so `x_valid`=1 in cycle N+1.
- One frame occupies W cycles of `x_valid`=1.
- Total busy cycles = (rep+1)·W + rep·GAP.
- `done` rises in the cycle after the last data bit and lasts 1 cycle.
- The earliest re-start is `start` sampled in the cycle after `done`.
- Abort asserted before edge M: `x_valid`=0 and `done`=1 after edge M.
- Reset asserted mid-operation clears all outputs immediately (asynchronously). After `rst` falls, the block sits in IDLE and needs a fresh `start`.

## Structure
- Package `seq_pkg` holds:
  - the state enum {IDLE, SHIFT, GAP, DONE}, 2 bits;
  - the `DEF_PAT` 101 constant;
  - the `REP_W`=4 and `GAP_W`=4 constants.
- Sub-module `seq_gen_cnt` is a generic loadable down/up counter with a terminal-count flag. It is instantiated for the bit counter and the gap counter.
- The FSM, shift register and frame counter stay in the top module.

## Test plan
- Reset, then `use_def`=1, `rep`=0, `GAP`=0, `start` pulse → `x_valid` high for 3 cycles with `x`=1,0,1; `done` pulses in the following cycle; `busy`=1 for exactly 3 cycles.
- `pattern`=4'b1100 (W=4), `rep`=2, `GAP`=2 → `x` = 1100, 2 idle cycles, 1100, 2 idle cycles, 1100; `busy`=16 cycles; a single `done` pulse.
- `start` held high continuously during a transmission with `rep`=1 → exactly 2 frames are sent; the next transmission begins only after `start` is sampled in IDLE, i.e. 1 cycle after `done`.
- `abort` asserted on the 2nd bit of the first frame, `rep`=3 → `x_valid`=0 on the next edge; `done`=1 for 1 cycle; no further bits are sent.
- `rst` raised mid-GAP → all outputs are 0 immediately; after release, `x_valid` stays 0 until a new `start`.
- Loopback: `x` feeds an overlapping 101 Moore detector (`x` gated with `x_valid`), default pattern, `rep`=1, `GAP`=0, giving the stream 101101 → the detector output pulses exactly twice, once after bit 3 and once after bit 6.
